// File: rtl/micro_sequencer_pkg.sv
// ucode_pkg: micro-address encodings, control-word layout and the control-store ROM.
// Build option: MICROSEQ_ILLEGAL_TRAP_EN turns the HALT entry into a self-loop trap.
package ucode_pkg;

   typedef logic [3:0] uaddr_t;

   localparam uaddr_t UA_FETCH     = 4'd0;
   localparam uaddr_t UA_DECODE    = 4'd1;
   localparam uaddr_t UA_MEMADR    = 4'd2;
   localparam uaddr_t UA_MEMREAD   = 4'd3;
   localparam uaddr_t UA_MEMWB     = 4'd4;
   localparam uaddr_t UA_MEMWRITE  = 4'd5;
   localparam uaddr_t UA_EXEC_R    = 4'd6;
   localparam uaddr_t UA_EXEC_I    = 4'd7;
   localparam uaddr_t UA_ALUWB     = 4'd8;
   localparam uaddr_t UA_BRANCH    = 4'd9;
   localparam uaddr_t UA_HALT      = 4'd10;
   localparam uaddr_t UA_RESERVED  = 4'hD;
   localparam uaddr_t UA_DISPATCH1 = 4'hE;
   localparam uaddr_t UA_DISPATCH2 = 4'hF;

   // MSB first, exactly the control_word bit order
   typedef struct packed {
      logic       next_pc;
      logic       reg_w;
      logic       mem_w;
      logic       ir_write;
      logic       adr_src;
      logic [1:0] result_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       branch;
      logic       alu_op;
      uaddr_t     next_adr;
   } cw_t;

   // Control store contents; unused addresses read 0 and so fall back to FETCH
   function automatic cw_t ucode_rom(input uaddr_t a);
      logic [15:0] w;
      case (a)
         UA_FETCH:    w = 16'h9581;
         UA_DECODE:   w = 16'h058E;
         UA_MEMADR:   w = 16'h004F;
         UA_MEMREAD:  w = 16'h0804;
         UA_MEMWB:    w = 16'h4200;
         UA_MEMWRITE: w = 16'h2800;
         UA_EXEC_R:   w = 16'h0018;
         UA_EXEC_I:   w = 16'h0058;
         UA_ALUWB:    w = 16'h4000;
         UA_BRANCH:   w = 16'h0460;
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
         UA_HALT:     w = 16'h000A;
`else
         UA_HALT:     w = 16'h0000;
`endif
         default:     w = 16'h0000;
      endcase
      return cw_t'(w);
   endfunction

endpackage

// File: rtl/micro_sequencer_dispatch.sv
// micro_dispatch: resolves the nextAdr field, including the Decode and MemAdr dispatches.
// Build option: MICROSEQ_ILLEGAL_TRAP_EN sends op=11 to HALT instead of FETCH.
module micro_dispatch
   import ucode_pkg::*;
(
   input  uaddr_t     next_adr,
   input  logic [1:0] op,
   input  logic       funct_i,
   input  logic       funct_l,
   output uaddr_t     resolved
);

   // Direct jumps pass through; the two dispatch codes decode the instruction
   always_comb begin
      resolved = next_adr;
      case (next_adr)
         UA_DISPATCH1: begin
            case (op)
               2'b00:   resolved = funct_i ? UA_EXEC_I : UA_EXEC_R;
               2'b01:   resolved = UA_MEMADR;
               2'b10:   resolved = UA_BRANCH;
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
               default: resolved = UA_HALT;
`else
               default: resolved = UA_FETCH;
`endif
            endcase
         end
         UA_DISPATCH2: resolved = funct_l ? UA_MEMREAD : UA_MEMWRITE;
         UA_RESERVED:  resolved = UA_FETCH;
         default:      resolved = next_adr;
      endcase
   end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: micro-PC register, control-store read, stall/reset masking, retire pulse.
// Build option: MICROSEQ_ILLEGAL_TRAP_EN adds the HALT trap and the illegal_op port.
module micro_sequencer
   import ucode_pkg::*;
#(
   parameter int UADDR_W = 4,
   parameter int CW_W    = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         op,
   input  logic               funct_i,
   input  logic               funct_l,
   input  logic               stall,
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
   output logic               illegal_op,
`endif
   output logic [CW_W-1:0]    control_word,
   output logic [UADDR_W-1:0] upc,
   output logic               retire
);

   // Write enables that must not fire while memory holds the sequencer
   localparam logic [15:0] STALL_KEEP = 16'h0FDF;

   uaddr_t upc_q, upc_d, resolved;
   cw_t    rom_word;

   assign rom_word = ucode_rom(upc_q);

   micro_dispatch u_dispatch (
      .next_adr (rom_word.next_adr),
      .op       (op),
      .funct_i  (funct_i),
      .funct_l  (funct_l),
      .resolved (resolved)
   );

   // State register: uPC, synchronous reset to FETCH
   always_ff @(posedge clk) begin
      if (reset) upc_q <= UA_FETCH;
      else       upc_q <= upc_d;
   end

   // Next state: hold under stall, otherwise follow the resolved address
   always_comb begin
      upc_d = stall ? upc_q : resolved;
   end

   // Outputs: masked control word, retire on the final micro-op of an instruction
   always_comb begin
      control_word = '0;
      upc          = '0;
      retire       = 1'b0;
      if (!reset) begin
         upc          = upc_q;
         control_word = stall ? (rom_word & STALL_KEEP) : rom_word;
         retire       = !stall && (resolved == UA_FETCH) &&
                        (upc_q == UA_MEMWB  || upc_q == UA_MEMWRITE ||
                         upc_q == UA_ALUWB  || upc_q == UA_BRANCH   ||
                         upc_q == UA_DECODE);
      end
   end

`ifdef MICROSEQ_ILLEGAL_TRAP_EN
   // Trap indicator follows the HALT state directly
   always_comb begin
      illegal_op = !reset && (upc_q == UA_HALT);
   end
`endif

endmodule

// File: tb/tb_micro_sequencer.sv
// Testbench for micro_sequencer: directed vector table, corner sequences and a
// randomized instruction stream checked against a path-level reference model.
module tb_micro_sequencer;

   logic        clk = 1'b0;
   logic        reset, stall, funct_i, funct_l;
   logic [1:0]  op;
   logic [15:0] control_word;
   logic [3:0]  upc;
   logic        retire;
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
   logic        illegal_op;
`endif

   int checks = 0;
   int errors = 0;

   micro_sequencer dut (
      .clk          (clk),
      .reset        (reset),
      .op           (op),
      .funct_i      (funct_i),
      .funct_l      (funct_l),
      .stall        (stall),
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
      .illegal_op   (illegal_op),
`endif
      .control_word (control_word),
      .upc          (upc),
      .retire       (retire)
   );

   always #5 clk = ~clk;

   // Expected ROM contents by state, from the field meanings of each micro-op
   logic [15:0] word_of [16];
   initial begin
      for (int i = 0; i < 16; i++) word_of[i] = 16'h0000;
      word_of[0] = 16'h9581; word_of[1] = 16'h058E; word_of[2] = 16'h004F;
      word_of[3] = 16'h0804; word_of[4] = 16'h4200; word_of[5] = 16'h2800;
      word_of[6] = 16'h0018; word_of[7] = 16'h0058; word_of[8] = 16'h4000;
      word_of[9] = 16'h0460;
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
      word_of[10] = 16'h000A;
`endif
   end

   function automatic logic [15:0] masked(input logic [15:0] w, input logic s);
      // stall clears NextPC, RegW, MemW, IRWrite (15:12) and Branch (5)
      return s ? (w & ~16'hF020) : w;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic s, input logic [1:0] o,
                        input logic fi, input logic fl);
      @(negedge clk);
      reset = r; stall = s; op = o; funct_i = fi; funct_l = fl;
      #1;
   endtask

   typedef struct {
      logic        r, s;
      logic [1:0]  o;
      logic        fi, fl;
      logic [3:0]  e_upc;
      logic [15:0] e_cw;
      logic        e_ret;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(input logic r, input logic s, input logic [1:0] o,
                               input logic fi, input logic fl, input logic [3:0] u,
                               input logic [15:0] w, input logic ret);
      vec_t v;
      v.r = r; v.s = s; v.o = o; v.fi = fi; v.fl = fl;
      v.e_upc = u; v.e_cw = w; v.e_ret = ret;
      return v;
   endfunction

   // Path (sequence of micro-addresses) an instruction takes from FETCH
   function automatic void path_of(input logic [1:0] o, input logic fi, input logic fl,
                                   output int p[$]);
      p = {};
      case (o)
         2'b00: p = fi ? '{0, 1, 7, 8} : '{0, 1, 6, 8};
         2'b01: p = fl ? '{0, 1, 2, 3, 4} : '{0, 1, 2, 5};
         2'b10: p = '{0, 1, 9};
         default: p = '{0, 1};
      endcase
   endfunction

   initial begin
      int p[$];
      reset = 1'b1; stall = 1'b0; op = 2'b00; funct_i = 1'b0; funct_l = 1'b0;

      // ---------------- directed table ----------------
      vt.push_back(mk(1,0,2'b00,0,0, 0, 16'h0000, 0));
      vt.push_back(mk(1,0,2'b00,0,0, 0, 16'h0000, 0));
      // LDR
      vt.push_back(mk(0,0,2'b01,0,1, 0, 16'h9581, 0));
      vt.push_back(mk(0,0,2'b01,0,1, 1, 16'h058E, 0));
      vt.push_back(mk(0,0,2'b01,0,1, 2, 16'h004F, 0));
      vt.push_back(mk(0,0,2'b01,0,1, 3, 16'h0804, 0));
      vt.push_back(mk(0,0,2'b01,0,1, 4, 16'h4200, 1));
      // STR with 3-cycle stall in MEMWRITE
      vt.push_back(mk(0,0,2'b01,0,0, 0, 16'h9581, 0));
      vt.push_back(mk(0,0,2'b01,0,0, 1, 16'h058E, 0));
      vt.push_back(mk(0,0,2'b01,0,0, 2, 16'h004F, 0));
      vt.push_back(mk(0,1,2'b01,0,0, 5, 16'h0800, 0));
      vt.push_back(mk(0,1,2'b01,0,0, 5, 16'h0800, 0));
      vt.push_back(mk(0,1,2'b01,0,0, 5, 16'h0800, 0));
      vt.push_back(mk(0,0,2'b01,0,0, 5, 16'h2800, 1));
      // DP immediate, with a stall in FETCH
      vt.push_back(mk(0,1,2'b00,1,0, 0, 16'h0581, 0));
      vt.push_back(mk(0,0,2'b00,1,0, 0, 16'h9581, 0));
      vt.push_back(mk(0,0,2'b00,1,0, 1, 16'h058E, 0));
      vt.push_back(mk(0,0,2'b00,1,0, 7, 16'h0058, 0));
      vt.push_back(mk(0,0,2'b00,1,0, 8, 16'h4000, 1));
      // Stall in DECODE: op changes while stalled, re-sampled on release -> MEMADR
      vt.push_back(mk(0,0,2'b10,0,0, 0, 16'h9581, 0));
      vt.push_back(mk(0,1,2'b10,0,0, 1, 16'h058E, 0));
      vt.push_back(mk(0,0,2'b01,0,0, 1, 16'h058E, 0));
      vt.push_back(mk(0,0,2'b01,0,0, 2, 16'h004F, 0));
      vt.push_back(mk(0,0,2'b01,0,0, 5, 16'h2800, 1));
      // DP register then branch
      vt.push_back(mk(0,0,2'b00,0,1, 0, 16'h9581, 0));
      vt.push_back(mk(0,0,2'b00,0,1, 1, 16'h058E, 0));
      vt.push_back(mk(0,0,2'b00,0,1, 6, 16'h0018, 0));
      vt.push_back(mk(0,0,2'b00,0,1, 8, 16'h4000, 1));
      vt.push_back(mk(0,0,2'b10,1,1, 0, 16'h9581, 0));
      vt.push_back(mk(0,0,2'b10,1,1, 1, 16'h058E, 0));
      vt.push_back(mk(0,1,2'b10,1,1, 9, 16'h0440, 0));
      vt.push_back(mk(0,0,2'b10,1,1, 9, 16'h0460, 1));
      vt.push_back(mk(0,0,2'b10,1,1, 0, 16'h9581, 0));

      foreach (vt[i]) begin
         drive(vt[i].r, vt[i].s, vt[i].o, vt[i].fi, vt[i].fl);
         chk($sformatf("vec%0d upc", i), {28'd0, upc}, {28'd0, vt[i].e_upc});
         chk($sformatf("vec%0d cw", i), {16'd0, control_word}, {16'd0, vt[i].e_cw});
         chk($sformatf("vec%0d retire", i), {31'd0, retire}, {31'd0, vt[i].e_ret});
      end

      // ---------------- reset mid-instruction at MEMREAD ----------------
      drive(1,0,2'b01,0,1); drive(0,0,2'b01,0,1); drive(0,0,2'b01,0,1);
      drive(0,0,2'b01,0,1); drive(0,0,2'b01,0,1);
      chk("pre-reset upc", {28'd0, upc}, 32'd3);
      drive(1,0,2'b01,0,1);
      chk("midreset cw", {16'd0, control_word}, 32'd0);
      chk("midreset upc", {28'd0, upc}, 32'd0);
      chk("midreset retire", {31'd0, retire}, 32'd0);
      drive(0,0,2'b01,0,1);
      chk("after reset upc", {28'd0, upc}, 32'd0);
      chk("after reset cw", {16'd0, control_word}, 32'h9581);
      chk("after reset retire", {31'd0, retire}, 32'd0);

      // ---------------- random stream vs path model ----------------
      drive(1,0,2'b00,0,0);
      begin
         logic [1:0] ro;
         logic rfi, rfl, rs;
         int q[$];
         for (int c = 0; c < 3000; c++) begin
            if (q.size() == 0) begin
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
               ro = 2'($urandom_range(0, 2));
`else
               ro = 2'($urandom_range(0, 3));
`endif
               rfi = 1'($urandom); rfl = 1'($urandom);
               path_of(ro, rfi, rfl, q);
            end
            rs = ($urandom_range(0, 3) == 0);
            drive(0, rs, ro, rfi, rfl);
            chk("rand upc", {28'd0, upc}, q[0]);
            chk("rand cw", {16'd0, control_word}, {16'd0, masked(word_of[q[0]], rs)});
            chk("rand retire", {31'd0, retire}, {31'd0, (!rs && q.size() == 1)});
            if (!rs) void'(q.pop_front());
         end
      end

      // ---------------- op=11 ----------------
      drive(1,0,2'b11,0,0);
      drive(0,0,2'b11,0,0);
      chk("op11 fetch upc", {28'd0, upc}, 32'd0);
      drive(0,0,2'b11,0,0);
      chk("op11 decode upc", {28'd0, upc}, 32'd1);
`ifdef MICROSEQ_ILLEGAL_TRAP_EN
      chk("op11 decode retire", {31'd0, retire}, 32'd0);
      for (int k = 0; k < 6; k++) begin
         drive(0, 1'(k == 2), 2'($urandom), 1'($urandom), 1'($urandom));
         chk("halt upc", {28'd0, upc}, 32'd10);
         chk("halt illegal_op", {31'd0, illegal_op}, 32'd1);
         chk("halt cw hi", {20'd0, control_word[15:4]}, 32'd0);
         chk("halt retire", {31'd0, retire}, 32'd0);
      end
      drive(1,0,2'b00,0,0);
      chk("reset illegal_op", {31'd0, illegal_op}, 32'd0);
      chk("reset upc", {28'd0, upc}, 32'd0);
      drive(0,0,2'b00,0,0);
      chk("exit halt upc", {28'd0, upc}, 32'd0);
      chk("exit halt illegal_op", {31'd0, illegal_op}, 32'd0);
`else
      chk("op11 decode retire", {31'd0, retire}, 32'd1);
      drive(0,0,2'b11,0,0);
      chk("op11 back upc", {28'd0, upc}, 32'd0);
      chk("op11 back retire", {31'd0, retire}, 32'd0);
      // unused address space is never reachable; reserved-code path covered by dispatch
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
